// File: rtl/tt_weight_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tt_weight_loader_if
// Brief    : Byte-load, weight and row-sequencing bundle for tt_weight_loader.
// Revision : 1.0 - initial release
// ============================================================================
interface tt_weight_loader_if #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int BYTE_W  = 8
);
    logic                          load_start;
    logic [BYTE_W-1:0]             byte_in;
    logic                          byte_valid;
    logic                          byte_ready;
    logic [2*IN_LEN*OUT_LEN-1:0]   W;
    logic                          w_valid;
    logic                          run;
    logic [2:0]                    row;
    logic                          en;
    logic                          pass_done;
    logic                          err;

    modport master (
        output load_start, byte_in, byte_valid, run,
        input  byte_ready, W, w_valid, row, en, pass_done, err
    );

    modport slave (
        input  load_start, byte_in, byte_valid, run,
        output byte_ready, W, w_valid, row, en, pass_done, err
    );
endinterface
`default_nettype wire

// File: rtl/tt_weight_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tt_weight_loader
// Brief    : Byte-serial ternary weight loader and row sequencer for the
//            matrix-vector multiplier. Optional TERNARY_CANON_EN macro turns
//            illegal '10' codes into '00' and raises a sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module tt_weight_loader #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int BYTE_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tt_weight_loader_if.slave  bus
);
    localparam int c_W_BITS = 2 * IN_LEN * OUT_LEN;
    localparam int c_NBYTES = c_W_BITS / BYTE_W;
    localparam int c_IDX_W  = $clog2(c_NBYTES);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [2:0]           r_row;
    logic [2:0]           w_row_next;
    logic                 w_accept;
    logic [c_W_BITS-1:0]  r_w;
    logic                 r_en;
    logic                 r_pass_done;
    logic                 r_byte_ready;
    logic                 r_w_valid;
    logic [BYTE_W-1:0]    w_byte;

`ifdef TERNARY_CANON_EN
    logic [BYTE_W/2-1:0]  w_bad;
    logic                 r_err;

    for (genvar gi = 0; gi < BYTE_W / 2; gi++) begin : g_canon
        assign w_bad[gi] = (bus.byte_in[2*gi +: 2] == 2'b10);
        assign w_byte[2*gi +: 2] = w_bad[gi] ? 2'b00 : bus.byte_in[2*gi +: 2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (|w_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_byte  = bus.byte_in;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_row_next = 3'd0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_start) begin
                    w_next     = S_LOAD;
                    w_idx_next = '0;
                end
            end
            S_LOAD: begin
                // A byte coinciding with load_start belongs to the abandoned load.
                if (bus.load_start) begin
                    w_idx_next = '0;
                end else if (bus.byte_valid) begin
                    w_accept   = 1'b1;
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == c_LAST) begin
                        w_next = S_READY;
                    end
                end
            end
            S_READY: begin
                if (bus.load_start) begin
                    w_next     = S_LOAD;
                    w_idx_next = '0;
                end else if (bus.run) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // run is only honoured at the pass boundary; row wraps 7 -> 0.
                w_row_next = r_row + 3'd1;
                if (r_row == 3'd7 && !bus.run) begin
                    w_next = S_READY;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_row        <= 3'd0;
            r_en         <= 1'b0;
            r_pass_done  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_w_valid    <= 1'b0;
            r_w          <= '0;
        end else begin
            r_state      <= w_next;
            r_idx        <= w_idx_next;
            r_row        <= (w_next == S_RUN) ? w_row_next : 3'd0;
            r_en         <= (w_next == S_RUN);
            r_pass_done  <= (w_next == S_RUN) && (w_row_next == 3'd7);
            r_byte_ready <= (w_next == S_LOAD);
            r_w_valid    <= (w_next == S_READY) || (w_next == S_RUN);
            for (int k = 0; k < c_NBYTES; k++) begin
                if (w_accept && (r_idx == c_IDX_W'(k))) begin
                    r_w[k*BYTE_W +: BYTE_W] <= w_byte;
                end
            end
        end
    end

    assign bus.W          = r_w;
    assign bus.w_valid    = r_w_valid;
    assign bus.byte_ready = r_byte_ready;
    assign bus.row        = r_row;
    assign bus.en         = r_en;
    assign bus.pass_done  = r_pass_done;
endmodule
`default_nettype wire

// File: tb/tb_tt_weight_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tt_weight_loader
// Brief    : Scoreboard bench for tt_weight_loader (loads, passes, restart,
//            priority, canonicalization when TERNARY_CANON_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_weight_loader;
    localparam int c_PERIOD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(c_PERIOD/2) clk = ~clk;

    tt_weight_loader_if bus ();

    tt_weight_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] row;
        logic       pd;
    } row_exp_t;

    typedef struct {
        logic [255:0] w;
        logic         err;
    } load_exp_t;

    row_exp_t  rq[$];
    load_exp_t lq[$];
    int        checks   = 0;
    int        failures = 0;
    logic      exp_err  = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] canon(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef TERNARY_CANON_EN
        for (int i = 0; i < 4; i++) begin
            if (r[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
        end
`endif
        return r;
    endfunction

    function automatic logic has_bad(input logic [7:0] b);
        logic r;
        r = 1'b0;
`ifdef TERNARY_CANON_EN
        for (int i = 0; i < 4; i++) begin
            if (b[2*i +: 2] == 2'b10) r = 1'b1;
        end
`endif
        return r;
    endfunction

    // Monitor: pops row expectations while en is high, load expectations on w_valid rise.
    initial begin
        logic prev_wv;
        row_exp_t  re;
        load_exp_t le;
        prev_wv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.en === 1'b1) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_en: got en=1 row=%0d expected en=0", bus.row);
                end else begin
                    re = rq.pop_front();
                    chk("row", {253'd0, bus.row}, {253'd0, re.row});
                    chk("pass_done", {255'd0, bus.pass_done}, {255'd0, re.pd});
                end
            end else if (bus.pass_done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL pass_done_idle: got %b expected 0", bus.pass_done);
            end
            if (bus.w_valid === 1'b1 && !prev_wv) begin
                if (lq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_w_valid: got 1 expected 0");
                end else begin
                    le = lq.pop_front();
                    chk("W_loaded", bus.W, le.w);
                    chk("err_loaded", {255'd0, bus.err}, {255'd0, le.err});
                end
            end
            prev_wv = (bus.w_valid === 1'b1);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " byte_ready"}, {255'd0, bus.byte_ready}, 256'd0);
        chk({tag, " w_valid"},    {255'd0, bus.w_valid},    256'd0);
        chk({tag, " en"},         {255'd0, bus.en},         256'd0);
        chk({tag, " row"},        {253'd0, bus.row},        256'd0);
        chk({tag, " pass_done"},  {255'd0, bus.pass_done},  256'd0);
        chk({tag, " err"},        {255'd0, bus.err},        256'd0);
        chk({tag, " W"},          bus.W,                    256'd0);
    endtask

    task automatic do_load(input logic [255:0] bv, input bit gap, input int exp_span,
                           input int pre, input string tag);
        logic [255:0] ew;
        time t_first, t_last;
        int  t;
        t_first = 0;
        t_last  = 0;
        for (int k = 0; k < 32; k++) begin
            ew[8*k +: 8] = canon(bv[8*k +: 8]);
            if (has_bad(bv[8*k +: 8])) exp_err = 1'b1;
        end
        lq.push_back('{ew, exp_err});
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int k = 0; k < pre; k++) begin
            bus.byte_in    = 8'h55;
            bus.byte_valid = 1'b1;
            @(negedge clk);
        end
        if (pre > 0) begin
            bus.load_start = 1'b1;
            @(negedge clk);
            bus.load_start = 1'b0;
        end
        for (int k = 0; k < 32; k++) begin
            bus.byte_in    = bv[8*k +: 8];
            bus.byte_valid = 1'b1;
            t = 0;
            while (bus.byte_ready !== 1'b1 && t < 8) begin
                @(negedge clk);
                t++;
            end
            if (bus.byte_ready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s byte_ready_timeout: got 0 expected 1 at byte %0d", tag, k);
                bus.byte_valid = 1'b0;
                return;
            end
            if (k == 31) chk({tag, " w_valid_before_last"}, {255'd0, bus.w_valid}, 256'd0);
            @(posedge clk);
            if (k == 0) t_first = $time;
            t_last = $time;
            @(negedge clk);
            if (k == 0) chk({tag, " first_byte_on_W"}, {248'd0, bus.W[7:0]}, {248'd0, canon(bv[7:0])});
            if (gap && k != 31) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.byte_valid = 1'b0;
        chk({tag, " w_valid_after_last"}, {255'd0, bus.w_valid}, 256'd1);
        chk({tag, " byte_ready_after_last"}, {255'd0, bus.byte_ready}, 256'd0);
        chk({tag, " accept_span"}, 256'((t_last - t_first) / c_PERIOD + 1), 256'(exp_span));
    endtask

    task automatic do_run(input int hold, input int passes, input int ls_at);
        for (int p = 0; p < passes; p++) begin
            for (int r = 0; r < 8; r++) rq.push_back('{3'(r), (r == 7)});
        end
        @(negedge clk);
        bus.run = 1'b1;
        for (int i = 1; i <= passes * 8 + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("run_start en", {255'd0, bus.en}, 256'd1);
                chk("run_start row", {253'd0, bus.row}, 256'd0);
            end
            if (i == hold) bus.run = 1'b0;
            if (i == ls_at) bus.load_start = 1'b1;
            if (i == ls_at + 1) bus.load_start = 1'b0;
        end
        chk("run_stop en", {255'd0, bus.en}, 256'd0);
        chk("run_stop row", {253'd0, bus.row}, 256'd0);
        chk("run_stop w_valid", {255'd0, bus.w_valid}, 256'd1);
        chk("run_stop byte_ready", {255'd0, bus.byte_ready}, 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] inc, pat;
        for (int k = 0; k < 32; k++) begin
            inc[8*k +: 8] = 8'(k);
            pat[8*k +: 8] = 8'(k * 7 + 3);
        end
        bus.load_start = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.run        = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // Reset in the middle of a load.
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.byte_in    = 8'hFF;
            bus.byte_valid = 1'b1;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        chk("midload W_byte9", {248'd0, bus.W[79:72]}, 256'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        check_reset_vals("midload_rst");

        do_load(inc, 1'b0, 32, 0, "full");
        chk("full W_lo", {248'd0, bus.W[7:0]}, 256'h00);
        chk("full W_hi", {248'd0, bus.W[255:248]}, 256'h1F);

        do_run(10, 2, 3);
        do_run(1, 1, -1);

        do_load(inc, 1'b1, 63, 0, "gap");
        do_load(pat, 1'b0, 32, 5, "restart");

        // load_start beats run in READY.
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.run        = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.run        = 1'b0;
        chk("prio byte_ready", {255'd0, bus.byte_ready}, 256'd1);
        chk("prio w_valid", {255'd0, bus.w_valid}, 256'd0);
        chk("prio en", {255'd0, bus.en}, 256'd0);

        do_load({32{8'hA6}}, 1'b0, 32, 0, "canon");
`ifdef TERNARY_CANON_EN
        chk("canon W_byte", {248'd0, bus.W[7:0]}, 256'h04);
        chk("canon err", {255'd0, bus.err}, 256'd1);
`else
        chk("canon W_byte", {248'd0, bus.W[7:0]}, 256'hA6);
        chk("canon err", {255'd0, bus.err}, 256'd0);
`endif

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("final_rst");
        repeat (2) @(negedge clk);
        chk("row_queue_drained", 256'(rq.size()), 256'd0);
        chk("load_queue_drained", 256'(lq.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tt_weight_loader.md
# tt_weight_loader

Write-side companion to the ternary matrix-vector multiplier. Streams the 256-bit packed ternary weight matrix in byte-serial from the tapeout pins, holds it stable, and then drives the multiplier's `row` sequence and `en` strobe for repeated 8-row passes. Sits between the top-level pin mux and the multiplier's `W`/`row`/`en` inputs.

## Interface
- `InLen`, 16, input-vector length (weight columns per output).
- `OutLen`, 8, output-vector length.
- `ByteW`, 8, load byte width; `2*InLen*OutLen` must be a multiple of `ByteW`.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  begin a new weight load.
- `byte_in`  in  ByteW  weight byte; 4 ternary codes, LSB code first.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `W`  out  2*InLen*OutLen  packed weights to the multiplier.
- `w_valid`  out  1  full matrix loaded and stable.
- `run`  in  1  request row sequencing.
- `row`  out  3  current row index to the multiplier.
- `en`  out  1  multiplier output-capture enable.
- `pass_done`  out  1  one-cycle pulse on the last row of each pass.
- `err`  out  1  sticky illegal-code flag (see Configuration).

## Operation
- Ternary code per weight: bit0 = nonzero, bit1 = negate. `00`=0, `01`=+1, `11`=−1, `10`=illegal.
- States: IDLE, LOAD, READY, RUN.
- IDLE: `byte_ready`=0, `w_valid`=0. `load_start`=1 → LOAD, byte index cleared to 0.
- LOAD: `byte_ready`=1. Accept on `byte_valid & byte_ready`; byte k written to `W[k*ByteW +: ByteW]`, index increments. Accept of byte 31 (last) → READY. `load_start` in LOAD restarts the index at 0; `W` contents not cleared. A byte offered in the same cycle as `load_start` is discarded.
- READY: `w_valid`=1, `W` frozen. `run`=1 → RUN. `load_start`=1 → LOAD (`w_valid` drops); `load_start` takes priority over `run`.
- RUN: `en`=1, `w_valid`=1; `row` increments by 1 each cycle, 7 → 0 wrap. `pass_done`=1 while `row`=7. At `row`=7: `run`=0 → READY, otherwise continue with `row`=0. Deasserting `run` mid-pass has no effect until `row`=7. `load_start` ignored in RUN.
- `row` held at 0 outside RUN; `en` is 0 outside RUN.
- `rst`=1: state IDLE, `W`=0, index 0, `row`=0, `en`=0, `w_valid`=0, `byte_ready`=0, `pass_done`=0, `err`=0. Applies from any state including mid-load and mid-pass.

## Timing
- All outputs registered; no combinational input-to-output path.
- Accepted byte visible on `W` the following cycle.
- `w_valid` rises the cycle after the final byte is accepted; `byte_ready` falls that same cycle.
- Minimum load: 32 cycles from first accept to last accept; back-to-back `byte_valid` accepted every cycle.
- `run` sampled in READY at edge N → `row`=0, `en`=1 from N+1; `row`=7 at N+8.
- Stop: `run`=0 sampled while `row`=7 at edge M → `en`=0, `row`=0 from M+1.
- `load_start` in READY at edge N → `byte_ready`=1, `w_valid`=0 from N+1.

## Configuration
- `TERNARY_CANON_EN` defined: each accepted byte is checked; any `10` code is written to `W` as `00` and sets `err` the cycle after accept. `err` stays set until `rst`.
- Undefined: bytes written verbatim; `err` tied to 0.

## Test plan
- Reset mid-load: load 10 bytes, assert `rst` one cycle → all outputs at reset values, `W`=0; a fresh 32-byte load completes normally.
- Full load: `load_start`, bytes 0x00..0x1F back-to-back → `W[7:0]`=0x00, `W[255:248]`=0x1F, `w_valid` high exactly one cycle after byte 0x1F accepted.
- Gapped load: `byte_valid` toggled every other cycle → same final `W`, 63 cycles from first to last accept.
- Run two passes: `run` high 10 cycles from READY → `row` 0..7,0..7, `pass_done` at both `row`=7, `en` drops the cycle after the second 7.
- Restart and priority: `load_start` at byte 5, then 32 bytes → index restarts at 0; `load_start` and `run` together in READY → LOAD.
- Canonicalization: byte 0xA6 (codes 10,01,10,10 from LSB) → `W` byte 0x04, `err`=1 with macro; 0xA6, `err`=0 without.
